aes_encrypt_serial: RTL and testbench
=====================================

Name: aes_encrypt_serial

Overview:
- Byte-serial AES-128 encryption control unit; the forward counterpart of the decryption path.
- Accepts 16 plaintext bytes and applies the initial AddRoundKey during load. Then runs 10 rounds (SubBytes+ShiftRows, MixColumns, AddRoundKey) over an internal 128-bit state, and presents the 128-bit ciphertext with a valid/ready handshake.
- Round-key bytes come from an external combinational key-schedule source, addressed by this block.

Parameters:
NR, 10, number of rounds (AES-128 only; other values unsupported)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
in_byte  input  8  plaintext byte
in_valid  input  1  in_byte valid
in_ready  output  1  block accepts a plaintext byte this cycle
key_byte  input  8  round-key byte for (key_round, key_idx); combinational, valid same cycle
key_round  output  4  round of requested key byte, 0..10
key_idx  output  4  byte index 0..15 of requested key byte
key_rd  output  1  key_byte consumed this cycle
data_out  output  128  ciphertext, byte 0 in [127:120]
out_valid  output  1  data_out valid
out_ready  input  1  consumer accepts data_out
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock domain. Reset is asynchronous and active-low: resetn low forces the FSM to IDLE and clears all counters, the state register, data_out, out_valid, key_rd and busy to 0. in_ready is 1 in IDLE.
- State byte k maps to row k%4, column k/4 (FIPS-197 column-major). Byte 0 is the first byte loaded and the first byte on data_out ([127:120]).
- S-box: uses the existing combinational forward S-box module subBytes, one instance.
- FSM states: IDLE, LOAD, SBSR, MIXCOL, ADDRK, DONE.
- IDLE/LOAD:
  - in_ready=1.
  - Each beat with in_valid&in_ready writes state[k] = in_byte ^ key_byte, with key_round=0, key_idx=k, key_rd=1, and k increments.
  - Gaps (in_valid=0) do not advance k and deassert key_rd.
  - The first accepted beat moves IDLE to LOAD.
  - The beat with k=15 moves to SBSR with round r=1.
  - in_ready=0 in all other states.
- SBSR: 16 cycles, k=0..15.
  - next[k] = S(state[4*(((k/4)+(k%4))%4) + k%4]).
  - Written to a shadow register. The shadow is copied to state on the edge that ends k=15.
  - Then goes to MIXCOL if r<10, otherwise ADDRK.
- MIXCOL: 4 cycles, column c=0..3.
  - Column c is replaced by the GF(2^8) multiply by {02,03,01,01} circulant.
  - xtime = shift left with conditional XOR 0x1B.
  - Then ADDRK.
- ADDRK: 16 cycles.
  - state[k] ^= key_byte, with key_round=r, key_idx=k, key_rd=1.
  - At k=15: if r<10, r increments and goes to SBSR; if r=10, data_out is loaded and the FSM goes to DONE.
- DONE: out_valid=1, data_out held stable. The out_valid&out_ready edge clears out_valid and returns to IDLE. There is no timeout under backpressure.
- Latency: counting the edge accepting byte 15 as edge 0, out_valid is high after edge 356 = 9*(16+4+16) + (16+16).
- key_round/key_idx are 0 when key_rd=0.
- in_valid while busy is ignored; no data is lost or corrupted.
- Reset mid-operation aborts immediately. The next block starts cleanly from IDLE with no residue in the state, shadow or counters.

Test Plan:
- Vector 1: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c (bench key-schedule model), back-to-back beats -> data_out=3925841d02dc09fbdc118597196a0b32 and out_valid high exactly 356 edges after the last beat.
- Vector 2: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, with random in_valid gaps during load -> data_out=69c4e0d86a7b0430d8cdb78070b4c55a. Also: key_rd pulses only on accepted beats; key_round sequence 0,1..10 with 16 reads per round.
- Backpressure: out_ready held low 50 cycles after out_valid -> data_out and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-round: resetn low during round 5 ADDRK -> outputs cleared asynchronously. Rerunning Vector 1 afterwards -> correct ciphertext, same latency.
- Two blocks consecutively with out_ready tied high -> both ciphertexts correct; the second load starts the cycle after DONE handshakes.
- Round-10 check: probe the FSM for round 10 -> no MIXCOL cycles; SBSR goes directly to ADDRK.

Source files
------------

// File: rtl/aes_encrypt_serial.sv
// ---------------------------------------------------------------------------
// aes_encrypt_serial
//
// Byte-serial AES-128 encryption engine.
//
// A block is loaded one plaintext byte per accepted beat. The initial
// AddRoundKey is folded into the load. The engine then walks the 128-bit
// state through NR rounds, touching one byte (or one column) per clock:
//   SBSR   : SubBytes + ShiftRows, 16 cycles, results gathered in a shadow
//   MIXCOL : MixColumns, 4 cycles, one column each (skipped in last round)
//   ADDRK  : AddRoundKey, 16 cycles, one round-key byte each
// The ciphertext is then offered on data_out with a valid/ready handshake.
//
// Round-key bytes come from an external combinational key schedule. This
// block drives the (key_round, key_idx) address and expects key_byte to be
// valid in the same cycle.
//
// Ports
//   clock      in   1    system clock, rising edge
//   resetn     in   1    asynchronous active-low reset
//   in_byte    in   8    plaintext byte
//   in_valid   in   1    in_byte valid
//   in_ready   out  1    a plaintext byte is accepted this cycle
//   key_byte   in   8    round-key byte for (key_round, key_idx)
//   key_round  out  4    round of requested key byte (0 when key_rd=0)
//   key_idx    out  4    byte index of requested key byte (0 when key_rd=0)
//   key_rd     out  1    key_byte consumed this cycle
//   data_out   out  128  ciphertext, byte 0 in [127:120]
//   out_valid  out  1    data_out valid
//   out_ready  in   1    consumer accepts data_out
//   busy       out  1    engine not idle
//
// State byte k sits at row k%4, column k/4 (FIPS-197 column-major order).
// ---------------------------------------------------------------------------

// Forward AES S-box, purely combinational.
// The S-box is computed as the GF(2^8) inverse followed by the affine map.
// No lookup table is used.
//   a_i  in   8  input byte
//   s_o  out  8  S(a_i)
module subBytes (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply in GF(2^8).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end else begin
                acc = acc;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

    // Inverse as a^254 = a^2 * a^4 * ... * a^128. This maps 0 to 0, as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] acc;
        p   = gf_mul(a, a);
        acc = p;
        for (int i = 0; i < 6; i++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
               {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign s_o = affine(gf_inv(a_i));

endmodule

module aes_encrypt_serial #(
    parameter int NR = 10
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   key_byte,
    output logic [3:0]   key_round,
    output logic [3:0]   key_idx,
    output logic         key_rd,
    output logic [127:0] data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam logic [3:0] LAST_ROUND = NR[3:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SBSR   = 3'd2,
        S_MIXCOL = 3'd3,
        S_ADDRK  = 3'd4,
        S_DONE   = 3'd5
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   k_q, k_d;          // byte index, or column index in MIXCOL
    logic [3:0]   r_q, r_d;          // current round
    logic [7:0]   st_q [16];
    logic [7:0]   st_d [16];
    logic [7:0]   sh_q [16];         // ShiftRows shadow, so reads see the old state
    logic [7:0]   sh_d [16];
    logic [127:0] dout_q, dout_d;
    logic         ov_q, ov_d;

    logic         in_ready_s;
    logic         key_rd_s;
    logic [3:0]   key_round_s;
    logic [3:0]   key_idx_s;
    logic [1:0]   src_col_s;
    logic [7:0]   sb_in_s;
    logic [7:0]   sb_out_s;
    logic [31:0]  mix_s;

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column: {02,03,01,01} circulant. Row 0 is in [31:24].
    function automatic logic [31:0] mix_column(input logic [7:0] a0, input logic [7:0] a1,
                                               input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] b0, b1, b2, b3;
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // ShiftRows source for output byte k: same row, column (col+row) mod 4.
    // The 2-bit sum wraps modulo 4 by construction.
    assign src_col_s = k_q[3:2] + k_q[1:0];
    assign sb_in_s   = st_q[{src_col_s, k_q[1:0]}];

    subBytes u_sbox (
        .a_i (sb_in_s),
        .s_o (sb_out_s)
    );

    assign mix_s = mix_column(st_q[{k_q[1:0], 2'd0}], st_q[{k_q[1:0], 2'd1}],
                              st_q[{k_q[1:0], 2'd2}], st_q[{k_q[1:0], 2'd3}]);

    // Next-state, datapath updates and combinational key/handshake outputs.
    always_comb begin
        fsm_d       = fsm_q;
        k_d         = k_q;
        r_d         = r_q;
        st_d        = st_q;
        sh_d        = sh_q;
        dout_d      = dout_q;
        ov_d        = ov_q;
        in_ready_s  = 1'b0;
        key_rd_s    = 1'b0;
        key_round_s = 4'd0;
        key_idx_s   = 4'd0;

        case (fsm_q)
            S_IDLE, S_LOAD: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    // The initial AddRoundKey is applied as the byte arrives.
                    key_rd_s   = 1'b1;
                    key_idx_s  = k_q;
                    st_d[k_q]  = in_byte ^ key_byte;
                    if (k_q == 4'd15) begin
                        fsm_d = S_SBSR;
                        k_d   = 4'd0;
                        r_d   = 4'd1;
                    end else begin
                        fsm_d = S_LOAD;
                        k_d   = k_q + 4'd1;
                    end
                end else begin
                    fsm_d = fsm_q;
                end
            end

            S_SBSR: begin
                sh_d[k_q] = sb_out_s;
                if (k_q == 4'd15) begin
                    // Commit the whole substituted and shifted state at once.
                    st_d  = sh_d;
                    k_d   = 4'd0;
                    fsm_d = (r_q == LAST_ROUND) ? S_ADDRK : S_MIXCOL;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end

            S_MIXCOL: begin
                st_d[{k_q[1:0], 2'd0}] = mix_s[31:24];
                st_d[{k_q[1:0], 2'd1}] = mix_s[23:16];
                st_d[{k_q[1:0], 2'd2}] = mix_s[15:8];
                st_d[{k_q[1:0], 2'd3}] = mix_s[7:0];
                if (k_q == 4'd3) begin
                    k_d   = 4'd0;
                    fsm_d = S_ADDRK;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end

            S_ADDRK: begin
                key_rd_s    = 1'b1;
                key_round_s = r_q;
                key_idx_s   = k_q;
                st_d[k_q]   = st_q[k_q] ^ key_byte;
                if (k_q == 4'd15) begin
                    k_d = 4'd0;
                    if (r_q == LAST_ROUND) begin
                        r_d   = 4'd0;
                        ov_d  = 1'b1;
                        fsm_d = S_DONE;
                        for (int j = 0; j < 16; j++) begin
                            dout_d[127 - 8*j -: 8] = st_d[j];
                        end
                    end else begin
                        r_d   = r_q + 4'd1;
                        fsm_d = S_SBSR;
                    end
                end else begin
                    k_d = k_q + 4'd1;
                end
            end

            S_DONE: begin
                // Hold the ciphertext indefinitely until it is taken.
                if (out_ready) begin
                    ov_d  = 1'b0;
                    fsm_d = S_IDLE;
                end else begin
                    ov_d  = 1'b1;
                end
            end

            default: begin
                fsm_d = S_IDLE;
                k_d   = 4'd0;
                r_d   = 4'd0;
                ov_d  = 1'b0;
            end
        endcase
    end

    // State register, counters, state/shadow arrays and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fsm_q  <= S_IDLE;
            k_q    <= 4'd0;
            r_q    <= 4'd0;
            dout_q <= 128'd0;
            ov_q   <= 1'b0;
            for (int j = 0; j < 16; j++) begin
                st_q[j] <= 8'h00;
                sh_q[j] <= 8'h00;
            end
        end else begin
            fsm_q  <= fsm_d;
            k_q    <= k_d;
            r_q    <= r_d;
            dout_q <= dout_d;
            ov_q   <= ov_d;
            st_q   <= st_d;
            sh_q   <= sh_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign key_rd    = key_rd_s;
    assign key_round = key_round_s;
    assign key_idx   = key_idx_s;
    assign data_out  = dout_q;
    assign out_valid = ov_q;
    assign busy      = (fsm_q != S_IDLE);

endmodule

// File: tb/tb_aes_encrypt_serial.sv
// Self-checking bench for aes_encrypt_serial.
// The bench provides a round-key source built from its own key expansion.
// Ciphertexts are checked against FIPS-197 known answers and against a
// byte-array reference AES model.
module tb_aes_encrypt_serial;

    logic         clock = 1'b0;
    logic         resetn = 1'b1;
    logic [7:0]   in_byte = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   key_byte;
    logic [3:0]   key_round;
    logic [3:0]   key_idx;
    logic         key_rd;
    logic [127:0] data_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sbox [256];
    logic [7:0] rk [16][16];

    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    assign key_byte = rk[key_round][key_idx];

    aes_encrypt_serial #(.NR(10)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_byte  (key_byte),
        .key_round (key_round),
        .key_idx   (key_idx),
        .key_rd    (key_rd),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Monitor: logs every key read and counts handshake/zeroing violations.
    int cyc = 0;
    int bad_keyrd = 0;
    int bad_zero = 0;
    int rd_round [$];
    int rd_idx [$];
    int rd_cyc [$];
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (resetn) begin
            if (key_rd === 1'b1) begin
                rd_round.push_back(int'(key_round));
                rd_idx.push_back(int'(key_idx));
                rd_cyc.push_back(cyc);
            end
            if (in_ready === 1'b1 && key_rd !== in_valid) bad_keyrd <= bad_keyrd + 1;
            if (key_rd === 1'b0 && (key_round !== 4'd0 || key_idx !== 4'd0)) bad_zero <= bad_zero + 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from exp/log tables over generator 3, then the affine map.
    task automatic build_sbox();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] x;
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = x;
            lg[x] = i;
            x = x ^ xt(x);
        end
        c = 8'h63;
        for (int v = 0; v < 256; v++) begin
            inv = (v == 0) ? 8'h00 : ex[(255 - lg[v]) % 255];
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox[v] = s;
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [7:0] kb [176];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [7:0] x;
        for (int j = 0; j < 16; j++) kb[j] = key[127 - 8*j -: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = kb[i - 4 + j];
            if (i % 16 == 0) begin
                x = tmp[0];
                tmp[0] = sbox[tmp[1]] ^ rc;
                tmp[1] = sbox[tmp[2]];
                tmp[2] = sbox[tmp[3]];
                tmp[3] = sbox[x];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) kb[i + j] = kb[i - 16 + j] ^ tmp[j];
        end
        for (int r = 0; r < 16; r++)
            for (int j = 0; j < 16; j++)
                if (r <= 10) rk[r][j] = kb[16*r + j];
                else rk[r][j] = 8'h00;
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] res;
        for (int j = 0; j < 16; j++) s[j] = pt[127 - 8*j -: 8] ^ rk[0][j];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int j = 0; j < 16; j++) t[j] = sbox[s[j]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c + r];
                    s[4*c + 0] = gmul(8'h02, a[0]) ^ gmul(8'h03, a[1]) ^ a[2] ^ a[3];
                    s[4*c + 1] = a[0] ^ gmul(8'h02, a[1]) ^ gmul(8'h03, a[2]) ^ a[3];
                    s[4*c + 2] = a[0] ^ a[1] ^ gmul(8'h02, a[2]) ^ gmul(8'h03, a[3]);
                    s[4*c + 3] = gmul(8'h03, a[0]) ^ a[1] ^ a[2] ^ gmul(8'h02, a[3]);
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ rk[rnd][j];
        end
        for (int j = 0; j < 16; j++) res[127 - 8*j -: 8] = s[j];
        return res;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive 16 beats. The beat for byte 15 is accepted on the final edge.
    task automatic load_block(input logic [127:0] pt, input int gap_pct);
        int g;
        for (int j = 0; j < 16; j++) begin
            g = 0;
            while (gap_pct > 0 && g < 4 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                tick();
                g++;
            end
            in_valid = 1'b1;
            in_byte  = pt[127 - 8*j -: 8];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Count edges from the byte-15 edge until out_valid; -1 on timeout.
    task automatic wait_out(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 2000) begin
            tick();
            edges++;
        end
        if (out_valid !== 1'b1) edges = -1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (data_out !== 128'd0) begin n_fail++; $display("FAIL reset_data_out got %h want 0", data_out); end
        n_tests++; if (key_rd !== 1'b0) begin n_fail++; $display("FAIL reset_key_rd got %b want 0", key_rd); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_vector1();
        int e;
        set_key(K1);
        load_block(PT1, 0);
        wait_out(e);
        n_tests++; if (e != 356) begin n_fail++; $display("FAIL v1_latency got %0d want 356", e); end
        n_tests++; if (data_out !== CT1) begin n_fail++; $display("FAIL v1_data got %h want %h", data_out, CT1); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL v1_busy_done got %b want 1", busy); end
        handshake();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL v1_release got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready); end
    endtask

    task automatic test_vector2();
        int e, s0, kr0, z0, nbad;
        set_key(K2);
        s0 = rd_round.size(); kr0 = bad_keyrd; z0 = bad_zero;
        load_block(PT2, 40);
        wait_out(e);
        n_tests++; if (data_out !== CT2) begin n_fail++; $display("FAIL v2_data got %h want %h", data_out, CT2); end
        n_tests++; if (rd_round.size() - s0 != 176) begin
            n_fail++; $display("FAIL v2_key_reads got %0d want 176", rd_round.size() - s0); end
        nbad = 0;
        for (int i = 0; i < 176 && s0 + i < rd_round.size(); i++)
            if (rd_round[s0 + i] != i / 16 || rd_idx[s0 + i] != i % 16) nbad++;
        n_tests++; if (nbad != 0) begin n_fail++; $display("FAIL v2_key_seq got %0d bad entries want 0", nbad); end
        n_tests++; if (bad_keyrd != kr0) begin n_fail++; $display("FAIL v2_key_rd_beats got %0d violations want 0", bad_keyrd - kr0); end
        n_tests++; if (bad_zero != z0) begin n_fail++; $display("FAIL v2_key_addr_zero got %0d violations want 0", bad_zero - z0); end
        handshake();
    endtask

    task automatic test_backpressure();
        int e;
        logic [127:0] pt, pt2, expv, held;
        set_key({$urandom, $urandom, $urandom, $urandom});
        pt = {$urandom, $urandom, $urandom, $urandom};
        expv = ref_encrypt(pt);
        load_block(pt, 0);
        wait_out(e);
        held = data_out;
        n_tests++; if (held !== expv) begin n_fail++; $display("FAIL bp_data got %h want %h", held, expv); end
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_byte  = 8'($urandom);
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || data_out !== held || in_ready !== 1'b0 || key_rd !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got ov=%b rdy=%b krd=%b busy=%b data=%h want 1 0 0 1 %h",
                         i, out_valid, in_ready, key_rd, busy, data_out, held);
            end
            tick();
        end
        in_valid = 1'b0;
        handshake();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got ov=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        expv = ref_encrypt(pt2);
        load_block(pt2, 20);
        wait_out(e);
        n_tests++; if (data_out !== expv) begin n_fail++; $display("FAIL bp_next_data got %h want %h", data_out, expv); end
        handshake();
    endtask

    task automatic test_round10();
        int e, s0, gap, want, nbad;
        logic [127:0] pt, expv;
        set_key({$urandom, $urandom, $urandom, $urandom});
        pt = {$urandom, $urandom, $urandom, $urandom};
        expv = ref_encrypt(pt);
        s0 = rd_cyc.size();
        load_block(pt, 0);
        wait_out(e);
        n_tests++; if (data_out !== expv) begin n_fail++; $display("FAIL r10_data got %h want %h", data_out, expv); end
        n_tests++;
        if (rd_cyc.size() - s0 != 176) begin
            n_fail++; $display("FAIL r10_reads got %0d want 176", rd_cyc.size() - s0);
        end else begin
            nbad = 0;
            for (int r = 1; r <= 10; r++) begin
                // Round 10 has no MixColumns: 16 SBSR cycles only, not 16+4.
                gap  = rd_cyc[s0 + 16*r] - rd_cyc[s0 + 16*r - 1];
                want = (r == 10) ? 17 : 21;
                if (gap != want) begin
                    nbad++;
                    $display("FAIL r10_gap round %0d got %0d want %0d", r, gap, want);
                end
            end
            if (nbad != 0) n_fail++;
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int e, n;
        set_key(K1);
        load_block(PT1, 0);
        n = 0;
        while (!(key_rd === 1'b1 && key_round === 4'd5 && key_idx === 4'd7) && n < 1000) begin
            tick();
            n++;
        end
        n_tests++; if (n >= 1000) begin n_fail++; $display("FAIL rm_find_round5 got timeout want round 5 read"); end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 128'd0 || key_rd !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_async_clear got busy=%b ov=%b krd=%b rdy=%b data=%h want 0 0 0 1 0",
                     busy, out_valid, key_rd, in_ready, data_out);
        end
        tick();
        resetn = 1'b1;
        tick();
        load_block(PT1, 0);
        wait_out(e);
        n_tests++; if (e != 356) begin n_fail++; $display("FAIL rm_latency got %0d want 356", e); end
        n_tests++; if (data_out !== CT1) begin n_fail++; $display("FAIL rm_data got %h want %h", data_out, CT1); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int e1, e2;
        logic [127:0] pa, pb, ea, eb;
        set_key({$urandom, $urandom, $urandom, $urandom});
        pa = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        ea = ref_encrypt(pa);
        eb = ref_encrypt(pb);
        out_ready = 1'b1;
        load_block(pa, 0);
        wait_out(e1);
        n_tests++; if (data_out !== ea) begin n_fail++; $display("FAIL b2b_first got %h want %h", data_out, ea); end
        tick();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_turnaround got rdy=%b ov=%b want 1 0", in_ready, out_valid); end
        load_block(pb, 0);
        wait_out(e2);
        n_tests++; if (e2 != 356) begin n_fail++; $display("FAIL b2b_latency got %0d want 356", e2); end
        n_tests++; if (data_out !== eb) begin n_fail++; $display("FAIL b2b_second got %h want %h", data_out, eb); end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_vector1();
        test_vector2();
        test_backpressure();
        test_round10();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
